// File: rtl/draw_rect_bg_ctl.sv
// -----------------------------------------------------------------------------
// draw_rect_bg_ctl
// Background renderer placed after the VGA timing generator. It paints
// coloured edge markers, a grey interior fill and a single configurable
// rectangle. The rectangle can be drawn as an outline, a blinking outline,
// a filled box, or hidden.
//
// The rectangle geometry arrives through a valid/ready port. It is held in a
// one-entry pending slot and copied to the active geometry only at frame
// start, which is the rising edge of vblnk_in. This keeps geometry changes
// out of the visible part of a frame.
//
// Every timing signal passes through two register stages, so the pixel
// colour stays aligned with the delayed timing signals.
//
// Ports
//   pclk, rst                     pixel clock, synchronous active-high reset
//   hcount_in/vcount_in [10:0]    incoming pixel position
//   hsync_in/hblnk_in             incoming horizontal sync and blank
//   vsync_in/vblnk_in             incoming vertical sync and blank
//   state [1:0]                   00 outline, 01 blink, 10 filled, 11 hidden
//   cfg_valid/cfg_ready           geometry handshake
//   cfg_x/cfg_y/cfg_w/cfg_h       rectangle top-left corner and size
//   *_out                         timing delayed by two cycles
//   rgb_out [11:0]                pixel colour aligned with *_out
// -----------------------------------------------------------------------------
module draw_rect_bg_ctl #(
   parameter int          H_ACTIVE     = 800,
   parameter int          V_ACTIVE     = 600,
   parameter int          BORDER_W     = 1,
   parameter int          OUTLINE_W    = 2,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [11:0] BG_COLOR     = 12'h888,
   parameter logic [11:0] RECT_COLOR   = 12'hc61
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic [10:0] hcount_in,
   input  logic        hsync_in,
   input  logic        hblnk_in,
   input  logic [10:0] vcount_in,
   input  logic        vsync_in,
   input  logic        vblnk_in,
   input  logic [1:0]  state,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [10:0] cfg_x,
   input  logic [10:0] cfg_y,
   input  logic [10:0] cfg_w,
   input  logic [10:0] cfg_h,
   output logic [10:0] hcount_out,
   output logic        hsync_out,
   output logic        hblnk_out,
   output logic [10:0] vcount_out,
   output logic        vsync_out,
   output logic        vblnk_out,
   output logic [11:0] rgb_out
);

   typedef enum logic [1:0] {
      MODE_OUTLINE = 2'b00,
      MODE_BLINK   = 2'b01,
      MODE_FILL    = 2'b10,
      MODE_HIDE    = 2'b11
   } mode_e;

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
   localparam logic [11:0] BW_C     = 12'(BORDER_W);
   localparam logic [11:0] OW_C     = 12'(OUTLINE_W);
   localparam logic [11:0] H_LAST_C = 12'(H_ACTIVE - BORDER_W);
   localparam logic [11:0] V_LAST_C = 12'(V_ACTIVE - BORDER_W);

   // Geometry storage and blink state
   logic [10:0]      pend_x_r, pend_y_r, pend_w_r, pend_h_r;
   logic [10:0]      act_x_r, act_y_r, act_w_r, act_h_r;
   logic             pend_full_r, pend_full_nxt_s, cfg_ready_r;
   logic [CNT_W-1:0] frame_cnt_r;
   logic             blink_on_r;

   // Stage 1 registers: delayed timing plus region flags
   logic [10:0] hcount_s1_r, vcount_s1_r;
   logic        hsync_s1_r, hblnk_s1_r, vsync_s1_r, vblnk_s1_r;
   logic        blank_s1_r, top_s1_r, bot_s1_r, left_s1_r, right_s1_r, rect_s1_r;

   logic        frame_start_s, accept_s;
   logic [11:0] h12_s, v12_s, x_end_s, y_end_s;
   logic        inside_s, outline_s, rect_hit_s;
   logic [11:0] rgb_nxt_s;

   // vblnk_s1_r is vblnk_in delayed by one cycle, so it doubles as the edge detector.
   assign frame_start_s = vblnk_in && !vblnk_s1_r;
   // An offer is refused in the frame-start cycle so the slot is not written while it is drained.
   assign accept_s      = cfg_valid && cfg_ready_r && !pend_full_r && !frame_start_s;
   assign cfg_ready     = cfg_ready_r;

   // Compute the next occupancy of the pending slot.
   always_comb begin
      pend_full_nxt_s = pend_full_r;
      if (frame_start_s && pend_full_r) begin
         pend_full_nxt_s = 1'b0;
      end else if (accept_s) begin
         pend_full_nxt_s = 1'b1;
      end else begin
         pend_full_nxt_s = pend_full_r;
      end
   end

   // Capture offered geometry and promote it to the active geometry at frame start.
   always_ff @(posedge pclk) begin
      if (rst) begin
         pend_x_r    <= 11'd0;
         pend_y_r    <= 11'd0;
         pend_w_r    <= 11'd0;
         pend_h_r    <= 11'd0;
         act_x_r     <= 11'd0;
         act_y_r     <= 11'd0;
         act_w_r     <= 11'd0;
         act_h_r     <= 11'd0;
         pend_full_r <= 1'b0;
         cfg_ready_r <= 1'b0;
      end else begin
         if (accept_s) begin
            pend_x_r <= cfg_x;
            pend_y_r <= cfg_y;
            pend_w_r <= cfg_w;
            pend_h_r <= cfg_h;
         end
         if (frame_start_s && pend_full_r) begin
            act_x_r <= pend_x_r;
            act_y_r <= pend_y_r;
            act_w_r <= pend_w_r;
            act_h_r <= pend_h_r;
         end
         pend_full_r <= pend_full_nxt_s;
         cfg_ready_r <= !pend_full_nxt_s;
      end
   end

   // Count frames and toggle the blink phase once every BLINK_FRAMES frames.
   always_ff @(posedge pclk) begin
      if (rst) begin
         frame_cnt_r <= {CNT_W{1'b0}};
         blink_on_r  <= 1'b1;
      end else if (frame_start_s) begin
         if (frame_cnt_r == CNT_LAST) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            blink_on_r  <= !blink_on_r;
         end else begin
            frame_cnt_r <= frame_cnt_r + CNT_W'(1'b1);
         end
      end
   end

   // Use 12-bit sums so that corner+size cannot wrap past the 11-bit range.
   assign h12_s   = {1'b0, hcount_in};
   assign v12_s   = {1'b0, vcount_in};
   assign x_end_s = {1'b0, act_x_r} + {1'b0, act_w_r};
   assign y_end_s = {1'b0, act_y_r} + {1'b0, act_h_r};

   // Test the current pixel against the rectangle and resolve the drawing mode.
   always_comb begin
      inside_s   = 1'b0;
      outline_s  = 1'b0;
      rect_hit_s = 1'b0;
      if ((act_w_r != 11'd0) && (act_h_r != 11'd0)) begin
         inside_s = (h12_s >= {1'b0, act_x_r}) && (h12_s < x_end_s) &&
                    (v12_s >= {1'b0, act_y_r}) && (v12_s < y_end_s);
      end else begin
         inside_s = 1'b0;
      end
      // Adding OW on the pixel side avoids underflow in x+w-OW. A box that is
      // too thin for two outlines is treated as all outline.
      outline_s = inside_s &&
                  ((h12_s < ({1'b0, act_x_r} + OW_C)) || ((h12_s + OW_C) >= x_end_s) ||
                   (v12_s < ({1'b0, act_y_r} + OW_C)) || ((v12_s + OW_C) >= y_end_s));
      case (mode_e'(state))
         MODE_OUTLINE: rect_hit_s = outline_s;
         MODE_BLINK:   rect_hit_s = outline_s && blink_on_r;
         MODE_FILL:    rect_hit_s = inside_s;
         MODE_HIDE:    rect_hit_s = 1'b0;
         default:      rect_hit_s = 1'b0;
      endcase
   end

   // Stage 1: register timing and region flags. Reset marks the stage as blank so the output is black.
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_s1_r <= 11'd0;
         vcount_s1_r <= 11'd0;
         hsync_s1_r  <= 1'b0;
         hblnk_s1_r  <= 1'b0;
         vsync_s1_r  <= 1'b0;
         vblnk_s1_r  <= 1'b0;
         blank_s1_r  <= 1'b1;
         top_s1_r    <= 1'b0;
         bot_s1_r    <= 1'b0;
         left_s1_r   <= 1'b0;
         right_s1_r  <= 1'b0;
         rect_s1_r   <= 1'b0;
      end else begin
         hcount_s1_r <= hcount_in;
         vcount_s1_r <= vcount_in;
         hsync_s1_r  <= hsync_in;
         hblnk_s1_r  <= hblnk_in;
         vsync_s1_r  <= vsync_in;
         vblnk_s1_r  <= vblnk_in;
         blank_s1_r  <= hblnk_in || vblnk_in;
         top_s1_r    <= v12_s < BW_C;
         bot_s1_r    <= v12_s >= V_LAST_C;
         left_s1_r   <= h12_s < BW_C;
         right_s1_r  <= h12_s >= H_LAST_C;
         rect_s1_r   <= rect_hit_s;
      end
   end

   // Select the pixel colour by fixed priority.
   always_comb begin
      rgb_nxt_s = BG_COLOR;
      if (blank_s1_r) begin
         rgb_nxt_s = 12'h000;
      end else if (top_s1_r) begin
         rgb_nxt_s = 12'hff0;
      end else if (bot_s1_r) begin
         rgb_nxt_s = 12'hf00;
      end else if (left_s1_r) begin
         rgb_nxt_s = 12'h0f0;
      end else if (right_s1_r) begin
         rgb_nxt_s = 12'h00f;
      end else if (rect_s1_r) begin
         rgb_nxt_s = RECT_COLOR;
      end else begin
         rgb_nxt_s = BG_COLOR;
      end
   end

   // Stage 2: register the outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         hcount_out <= 11'd0;
         vcount_out <= 11'd0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= 12'h000;
      end else begin
         hcount_out <= hcount_s1_r;
         vcount_out <= vcount_s1_r;
         hsync_out  <= hsync_s1_r;
         hblnk_out  <= hblnk_s1_r;
         vsync_out  <= vsync_s1_r;
         vblnk_out  <= vblnk_s1_r;
         rgb_out    <= rgb_nxt_s;
      end
   end

endmodule

// File: tb/tb_draw_rect_bg_ctl.sv
// -----------------------------------------------------------------------------
// tb_draw_rect_bg_ctl
// Scoreboard bench for draw_rect_bg_ctl. Every driven pixel pushes its
// expected colour and timing into a queue. The monitor pops one entry when
// that pixel reaches the outputs two cycles later.
// A frame consists of a few probe pixels followed by vertical blanking.
// -----------------------------------------------------------------------------
module tb_draw_rect_bg_ctl;

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic [10:0] hcount_in = 11'd0, vcount_in = 11'd0;
   logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
   logic [1:0]  state = 2'b00;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [10:0] cfg_x = 11'd0, cfg_y = 11'd0, cfg_w = 11'd0, cfg_h = 11'd0;
   logic [10:0] hcount_out, vcount_out;
   logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [11:0] rgb_out;

   int          total = 0;
   int          bad   = 0;
   string       phase = "init";
   logic        live  = 1'b0;
   logic        s1 = 1'b0, s2 = 1'b0;
   logic [37:0] sb_q[$];
   logic [37:0] sb_e;

   localparam logic [11:0] C_Y = 12'hff0, C_R = 12'hf00, C_G = 12'h0f0, C_B = 12'h00f;
   localparam logic [11:0] C_BG = 12'h888, C_RECT = 12'hc61, C_K = 12'h000;

   draw_rect_bg_ctl #(.BLINK_FRAMES(2)) dut (
      .pclk(pclk), .rst(rst),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .state(state), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s/%s got=%h exp=%h t=%0t", phase, tag, obs, exp, $time);
      end
   endtask

   // Drive one pixel, queue its expectation, and advance one clock.
   task automatic pix(input logic [10:0] h, input logic [10:0] v,
                      input logic hb, input logic vb, input logic [11:0] exp_rgb);
      logic hs, vs;
      hs = 1'($urandom);
      vs = 1'($urandom);
      hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
      hblnk_in = hb; vblnk_in = vb;
      live = 1'b1;
      sb_q.push_back({exp_rgb, h, v, hs, hb, vs, vb});
      @(posedge pclk);
      #1;
   endtask

   task automatic vbl(input int n);
      for (int i = 0; i < n; i++) pix(11'(i), 11'd600, 1'b1, 1'b1, C_K);
   endtask

   task automatic offer(input logic [10:0] x, input logic [10:0] y,
                        input logic [10:0] w, input logic [10:0] h);
      cfg_x = x; cfg_y = y; cfg_w = w; cfg_h = h;
      cfg_valid = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      live = 1'b0;
      cfg_valid = 1'b0;
      @(posedge pclk);
      #1;
      chk("rst_rgb", 32'(rgb_out), 32'd0);
      chk("rst_timing", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'd0);
      chk("rst_ready", 32'(cfg_ready), 32'd0);
      sb_q.delete();
      rst = 1'b0;
      pix(11'd0, 11'd0, 1'b1, 1'b0, C_K);
      chk("rel_ready", 32'(cfg_ready), 32'd1);
      chk("rel_rgb", 32'(rgb_out), 32'd0);
   endtask

   // Pipeline tags: s2 is set when the outputs hold a pixel the bench drove.
   always @(posedge pclk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= live;
         s2 <= s1;
      end
   end

   always @(negedge pclk) begin
      if (s2) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
         end else begin
            sb_e = sb_q.pop_front();
            chk("rgb", 32'(rgb_out), 32'(sb_e[37:26]));
            chk("timing", 32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}),
                32'(sb_e[25:0]));
         end
      end
   end

   initial begin
      // 1: reset values, edge markers and fill with no rectangle
      phase = "t1";
      do_reset();
      state = 2'b00;
      pix(11'd0,   11'd0,   1'b0, 1'b0, C_Y);
      pix(11'd0,   11'd599, 1'b0, 1'b0, C_R);
      pix(11'd0,   11'd300, 1'b0, 1'b0, C_G);
      pix(11'd799, 11'd300, 1'b0, 1'b0, C_B);
      pix(11'd400, 11'd300, 1'b0, 1'b0, C_BG);
      pix(11'd799, 11'd0,   1'b0, 1'b0, C_Y);
      pix(11'd400, 11'd300, 1'b1, 1'b0, C_K);
      pix(11'd400, 11'd300, 1'b0, 1'b1, C_K);
      pix(11'd1,   11'd1,   1'b0, 1'b0, C_BG);
      pix(11'd798, 11'd598, 1'b0, 1'b0, C_BG);
      pix(11'd0,   11'd1,   1'b0, 1'b0, C_G);

      // 2: geometry offered mid-frame appears only in the next frame
      phase = "t2";
      do_reset();
      pix(11'd300, 11'd200, 1'b0, 1'b0, C_BG);
      offer(11'd249, 11'd149, 11'd301, 11'd101);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);
      cfg_valid = 1'b0;
      chk("ready_after_accept", 32'(cfg_ready), 32'd0);
      pix(11'd249, 11'd149, 1'b0, 1'b0, C_BG);
      pix(11'd250, 11'd150, 1'b0, 1'b0, C_BG);
      pix(11'd549, 11'd249, 1'b0, 1'b0, C_BG);
      vbl(3);
      chk("ready_after_fs", 32'(cfg_ready), 32'd1);
      pix(11'd249, 11'd149, 1'b0, 1'b0, C_RECT);
      pix(11'd250, 11'd150, 1'b0, 1'b0, C_RECT);
      pix(11'd251, 11'd151, 1'b0, 1'b0, C_BG);
      pix(11'd549, 11'd249, 1'b0, 1'b0, C_RECT);
      pix(11'd550, 11'd249, 1'b0, 1'b0, C_BG);
      pix(11'd549, 11'd250, 1'b0, 1'b0, C_BG);
      pix(11'd248, 11'd149, 1'b0, 1'b0, C_BG);
      pix(11'd300, 11'd200, 1'b0, 1'b0, C_BG);
      pix(11'd300, 11'd150, 1'b0, 1'b0, C_RECT);
      pix(11'd300, 11'd151, 1'b0, 1'b0, C_BG);
      pix(11'd548, 11'd200, 1'b0, 1'b0, C_RECT);
      pix(11'd547, 11'd200, 1'b0, 1'b0, C_BG);
      vbl(2);

      // 3: second offer waits for the slot; A shows in frame 1, B in frame 2
      phase = "t3";
      do_reset();
      state = 2'b10;
      offer(11'd100, 11'd100, 11'd10, 11'd10);
      pix(11'd50, 11'd50, 1'b0, 1'b0, C_BG);
      offer(11'd200, 11'd200, 11'd10, 11'd10);
      pix(11'd60, 11'd60, 1'b0, 1'b0, C_BG);
      chk("ready_b_held", 32'(cfg_ready), 32'd0);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);
      pix(11'd200, 11'd200, 1'b0, 1'b0, C_BG);
      vbl(4);
      cfg_valid = 1'b0;
      chk("ready_b_pending", 32'(cfg_ready), 32'd0);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_RECT);
      pix(11'd109, 11'd109, 1'b0, 1'b0, C_RECT);
      pix(11'd110, 11'd110, 1'b0, 1'b0, C_BG);
      pix(11'd200, 11'd200, 1'b0, 1'b0, C_BG);
      vbl(3);
      chk("ready_b_applied", 32'(cfg_ready), 32'd1);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);
      pix(11'd200, 11'd200, 1'b0, 1'b0, C_RECT);
      pix(11'd209, 11'd209, 1'b0, 1'b0, C_RECT);
      vbl(2);

      // 4: blinking outline with a two-frame half period
      phase = "t4";
      do_reset();
      state = 2'b01;
      offer(11'd10, 11'd10, 11'd20, 11'd20);
      pix(11'd0, 11'd300, 1'b0, 1'b0, C_G);
      cfg_valid = 1'b0;
      pix(11'd10, 11'd10, 1'b0, 1'b0, C_BG);
      vbl(2);
      for (int f = 1; f <= 5; f++) begin
         logic [11:0] e_s;
         e_s = (f == 1 || f == 4 || f == 5) ? C_RECT : C_BG;
         pix(11'd10, 11'd10, 1'b0, 1'b0, e_s);
         pix(11'd29, 11'd29, 1'b0, 1'b0, e_s);
         pix(11'd20, 11'd20, 1'b0, 1'b0, C_BG);
         if (f == 2) begin
            state = 2'b00;
            pix(11'd10, 11'd10, 1'b0, 1'b0, C_RECT);
            state = 2'b01;
            pix(11'd11, 11'd11, 1'b0, 1'b0, C_BG);
         end
         vbl(2);
      end

      // 5: single-pixel box, all modes, clipped box and zero width
      phase = "t5";
      do_reset();
      state = 2'b10;
      offer(11'd400, 11'd300, 11'd1, 11'd1);
      pix(11'd0, 11'd0, 1'b0, 1'b0, C_Y);
      cfg_valid = 1'b0;
      vbl(2);
      pix(11'd400, 11'd300, 1'b0, 1'b0, C_RECT);
      pix(11'd401, 11'd300, 1'b0, 1'b0, C_BG);
      pix(11'd399, 11'd300, 1'b0, 1'b0, C_BG);
      pix(11'd400, 11'd301, 1'b0, 1'b0, C_BG);
      pix(11'd400, 11'd299, 1'b0, 1'b0, C_BG);
      state = 2'b00;
      pix(11'd400, 11'd300, 1'b0, 1'b0, C_RECT);
      state = 2'b11;
      pix(11'd400, 11'd300, 1'b0, 1'b0, C_BG);
      state = 2'b10;
      offer(11'd790, 11'd300, 11'd50, 11'd10);
      pix(11'd5, 11'd5, 1'b0, 1'b0, C_BG);
      cfg_valid = 1'b0;
      vbl(2);
      pix(11'd799, 11'd305, 1'b0, 1'b0, C_B);
      pix(11'd798, 11'd305, 1'b0, 1'b0, C_RECT);
      pix(11'd790, 11'd305, 1'b0, 1'b0, C_RECT);
      pix(11'd789, 11'd305, 1'b0, 1'b0, C_BG);
      pix(11'd795, 11'd309, 1'b0, 1'b0, C_RECT);
      pix(11'd795, 11'd310, 1'b0, 1'b0, C_BG);
      offer(11'd100, 11'd100, 11'd0, 11'd10);
      pix(11'd5, 11'd5, 1'b0, 1'b0, C_BG);
      cfg_valid = 1'b0;
      vbl(2);
      pix(11'd100, 11'd105, 1'b0, 1'b0, C_BG);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);
      state = 2'b00;
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);
      vbl(2);

      // 6: reset mid-line with a pending offer discards it
      phase = "t6";
      do_reset();
      state = 2'b10;
      offer(11'd100, 11'd100, 11'd50, 11'd50);
      pix(11'd10, 11'd10, 1'b0, 1'b0, C_BG);
      cfg_valid = 1'b0;
      chk("ready_pending", 32'(cfg_ready), 32'd0);
      pix(11'd20, 11'd20, 1'b0, 1'b0, C_BG);
      pix(11'd30, 11'd30, 1'b0, 1'b0, C_BG);
      do_reset();
      pix(11'd120, 11'd120, 1'b0, 1'b0, C_BG);
      vbl(2);
      chk("ready_no_pending", 32'(cfg_ready), 32'd1);
      pix(11'd120, 11'd120, 1'b0, 1'b0, C_BG);
      pix(11'd100, 11'd100, 1'b0, 1'b0, C_BG);

      // drain the pipeline
      phase = "end";
      live = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
